// File: rtl/vram_pkg.sv
// vram_pkg -- shared definitions for the text-mode VRAM writer.
//   Register-select addresses, CTRL/STATUS bit positions, sequencer
//   state type and reset constants used by vram_writer.
//   Optional macro VRAM_WRITER_SCROLL_EN (consumed by vram_writer) enables
//   hardware scrolling.
package vram_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_CURX   = 4'h1;
  localparam logic [3:0] REG_CURY   = 4'h2;
  localparam logic [3:0] REG_CURCH  = 4'h3;
  localparam logic [3:0] REG_HSHIFT = 4'h4;
  localparam logic [3:0] REG_ATTR   = 4'h5;
  localparam logic [3:0] REG_PUTC   = 4'h6;
  localparam logic [3:0] REG_PTRLO  = 4'h7;
  localparam logic [3:0] REG_PTRHI  = 4'h8;
  localparam logic [3:0] REG_SDATA  = 4'h9;
  localparam logic [3:0] REG_CDATA  = 4'hA;
  localparam logic [3:0] REG_FILL   = 4'hB;
  localparam logic [3:0] REG_STATUS = 4'hC;

  localparam int CTRL_MODE_BIT   = 0;
  localparam int CTRL_BLINK_BIT  = 1;
  localparam int CTRL_CURSOR_BIT = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

  localparam logic [7:0] RST_CURSOR_CH = 8'h5F;
  localparam logic [7:0] RST_ATTR      = 8'h07;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PUTC         = 3'd1,
    ST_FILL         = 3'd2,
    ST_SCROLL_COPY  = 3'd3,
    ST_SCROLL_CLEAR = 3'd4
  } vram_state_e;

endpackage

// File: rtl/vram_cell_addr.sv
// vram_cell_addr -- linear cell address of a text cursor position.
//   i_x    : column (0..COLS-1)
//   i_y    : row (0..ROWS-1)
//   o_addr : i_y*COLS + i_x, computed at 13 bits
module vram_cell_addr #(
  parameter int COLS = 80
) (
  input  logic [6:0]  i_x,
  input  logic [4:0]  i_y,
  output logic [12:0] o_addr
);

  localparam logic [12:0] L_COLS = 13'(COLS);

  // Operands are widened before the multiply so the product is not
  // truncated to the 5-bit row width.
  assign o_addr = {8'd0, i_y} * L_COLS + {6'd0, i_x};

endmodule

// File: rtl/vram_writer.sv
// vram_writer -- register-driven writer for a text-mode screen/color RAM.
//   clk, reset (async, active-high)
//   reg_addr/reg_wdata/reg_we/reg_rdata : register port, combinational read
//   busy                                : PUTC/FILL/SCROLL sequence running
//   s_* : screen RAM (13-bit address), c_* : color RAM (11-bit address),
//         both with 1-cycle read latency
//   mode, blink_on, cursor_on, cursor_x, cursor_y, cursor_ch, hshift :
//         display engine controls
// Macro VRAM_WRITER_SCROLL_EN: when defined, advancing past the last row
// scrolls the screen up one row; otherwise the cursor wraps to row 0 and
// the read ports are tied to 0.
//
// state           | meaning
// ST_IDLE         | waiting for register writes
// ST_PUTC         | writing one character at the cursor
// ST_FILL         | writing the fill byte to every cell
// ST_SCROLL_COPY  | moving rows 1..ROWS-1 up one row
// ST_SCROLL_CLEAR | blanking the last row
module vram_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_we,
  output logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [12:0] s_waddr,
  output logic [7:0]  s_wdata,
  output logic        s_we,
  output logic [12:0] s_raddr,
  input  logic [7:0]  s_rdata,
  output logic [10:0] c_waddr,
  output logic [7:0]  c_wdata,
  output logic        c_we,
  output logic [10:0] c_raddr,
  input  logic [7:0]  c_rdata,
  output logic        mode,
  output logic        blink_on,
  output logic        cursor_on,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [7:0]  cursor_ch,
  output logic [3:0]  hshift
);
  import vram_pkg::*;

  localparam logic [12:0] N_CELLS = 13'(COLS * ROWS);
  localparam logic [12:0] L_COLS  = 13'(COLS);
  localparam logic [6:0]  LAST_X  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_Y  = 5'(ROWS - 1);
  localparam logic [7:0]  MAX_X8  = 8'(COLS - 1);
  localparam logic [7:0]  MAX_Y8  = 8'(ROWS - 1);

  vram_state_e r_state, w_state_nxt;
  logic [12:0] r_idx, w_idx_nxt;
  logic [6:0]  r_cx, w_cx_nxt;
  logic [4:0]  r_cy, w_cy_nxt;
  logic        w_cur_set, w_row_adv;
  logic [7:0]  r_char, r_fill_data, r_attr, r_cch;
  logic [3:0]  r_hshift;
  logic        r_mode, r_blink, r_cur_on, r_err;
  logic [12:0] r_ptr;
  logic        r_sd_pend, r_cd_pend;
  logic [12:0] r_sd_addr;
  logic [10:0] r_cd_addr;
  logic [7:0]  r_sd_data, r_cd_data;
  logic        w_busy, w_seq_reg, w_drop;
  logic        w_fsm_we;
  logic [12:0] w_fsm_waddr, w_raddr, w_cell_addr;
  logic [7:0]  w_fsm_sdata, w_fsm_cdata;

  vram_cell_addr #(.COLS(COLS)) u_cell_addr (
    .i_x    (r_cx),
    .i_y    (r_cy),
    .o_addr (w_cell_addr)
  );

  assign w_busy    = (r_state != ST_IDLE);
  assign w_seq_reg = (reg_addr == REG_PUTC) || (reg_addr == REG_SDATA) ||
                     (reg_addr == REG_CDATA) || (reg_addr == REG_FILL);
  assign w_drop    = reg_we && w_busy && w_seq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cur_set   = 1'b0;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_row_adv   = 1'b0;
    w_fsm_we    = 1'b0;
    w_fsm_waddr = '0;
    w_fsm_sdata = '0;
    w_fsm_cdata = '0;
    w_raddr     = '0;
    case (r_state)
      ST_IDLE: begin
        if (reg_we && reg_addr == REG_PUTC) begin
          // Control characters only move the cursor, so they finish here.
          if (reg_wdata == CH_CR) begin
            w_cur_set = 1'b1;
            w_cx_nxt  = '0;
          end else if (reg_wdata == CH_LF) begin
            w_cur_set = 1'b1;
            w_cx_nxt  = '0;
            w_row_adv = 1'b1;
          end else begin
            w_state_nxt = ST_PUTC;
          end
        end else if (reg_we && reg_addr == REG_FILL) begin
          w_state_nxt = ST_FILL;
          w_idx_nxt   = '0;
        end
      end
      ST_PUTC: begin
        w_fsm_we    = 1'b1;
        w_fsm_waddr = w_cell_addr;
        w_fsm_sdata = r_char;
        w_fsm_cdata = r_attr;
        w_state_nxt = ST_IDLE;
        w_cur_set   = 1'b1;
        if (r_cx != LAST_X) begin
          w_cx_nxt = r_cx + 7'd1;
        end else begin
          w_cx_nxt  = '0;
          w_row_adv = 1'b1;
        end
      end
      ST_FILL: begin
        w_fsm_we    = 1'b1;
        w_fsm_waddr = r_idx;
        w_fsm_sdata = r_fill_data;
        w_fsm_cdata = r_attr;
        if (r_idx == N_CELLS - 13'd1) begin
          w_state_nxt = ST_IDLE;
          w_cur_set   = 1'b1;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
        end else begin
          w_idx_nxt = r_idx + 13'd1;
        end
      end
`ifdef VRAM_WRITER_SCROLL_EN
      ST_SCROLL_COPY: begin
        // Read of cell idx+COLS is issued this cycle; the cell read last
        // cycle (idx-1) is written now, so the copy takes one extra cycle.
        if (r_idx != N_CELLS - L_COLS) begin
          w_raddr = r_idx + L_COLS;
        end
        if (r_idx != 13'd0) begin
          w_fsm_we    = 1'b1;
          w_fsm_waddr = r_idx - 13'd1;
          w_fsm_sdata = s_rdata;
          w_fsm_cdata = c_rdata;
        end
        if (r_idx == N_CELLS - L_COLS) begin
          w_state_nxt = ST_SCROLL_CLEAR;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 13'd1;
        end
      end
      ST_SCROLL_CLEAR: begin
        w_fsm_we    = 1'b1;
        w_fsm_waddr = N_CELLS - L_COLS + r_idx;
        w_fsm_sdata = CH_SPACE;
        w_fsm_cdata = r_attr;
        if (r_idx == L_COLS - 13'd1) begin
          w_state_nxt = ST_IDLE;
          w_cur_set   = 1'b1;
          w_cx_nxt    = '0;
          w_cy_nxt    = LAST_Y;
        end else begin
          w_idx_nxt = r_idx + 13'd1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_row_adv) begin
      if (r_cy != LAST_Y) begin
        w_cy_nxt = r_cy + 5'd1;
      end else begin
`ifdef VRAM_WRITER_SCROLL_EN
        w_state_nxt = ST_SCROLL_COPY;
        w_idx_nxt   = '0;
`else
        w_cy_nxt = '0;
`endif
      end
    end
  end

`ifndef VRAM_WRITER_SCROLL_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^{s_rdata, c_rdata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_char      <= '0;
      r_fill_data <= '0;
      r_attr      <= RST_ATTR;
      r_cch       <= RST_CURSOR_CH;
      r_hshift    <= '0;
      r_mode      <= 1'b0;
      r_blink     <= 1'b0;
      r_cur_on    <= 1'b0;
      r_err       <= 1'b0;
      r_ptr       <= '0;
      r_sd_pend   <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_data   <= '0;
      r_cd_pend   <= 1'b0;
      r_cd_addr   <= '0;
      r_cd_data   <= '0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_sd_pend <= 1'b0;
      r_cd_pend <= 1'b0;
      if (reg_we) begin
        case (reg_addr)
          REG_CTRL: begin
            r_mode   <= reg_wdata[CTRL_MODE_BIT];
            r_blink  <= reg_wdata[CTRL_BLINK_BIT];
            r_cur_on <= reg_wdata[CTRL_CURSOR_BIT];
          end
          REG_CURX:   r_cx <= (reg_wdata > MAX_X8) ? LAST_X : reg_wdata[6:0];
          REG_CURY:   r_cy <= (reg_wdata > MAX_Y8) ? LAST_Y : reg_wdata[4:0];
          REG_CURCH:  r_cch <= reg_wdata;
          REG_HSHIFT: r_hshift <= reg_wdata[3:0];
          REG_ATTR:   r_attr <= reg_wdata;
          REG_PUTC:   if (!w_busy) r_char <= reg_wdata;
          REG_PTRLO:  r_ptr[7:0] <= reg_wdata;
          REG_PTRHI:  r_ptr[12:8] <= reg_wdata[4:0];
          REG_SDATA: begin
            if (!w_busy) begin
              r_sd_pend <= 1'b1;
              r_sd_addr <= r_ptr;
              r_sd_data <= reg_wdata;
              r_ptr     <= r_ptr + 13'd1;
            end
          end
          REG_CDATA: begin
            if (!w_busy) begin
              r_cd_pend <= 1'b1;
              r_cd_addr <= r_ptr[10:0];
              r_cd_data <= reg_wdata;
              r_ptr     <= r_ptr + 13'd1;
            end
          end
          REG_FILL:   if (!w_busy) r_fill_data <= reg_wdata;
          REG_STATUS: if (reg_wdata[STATUS_ERR_BIT]) r_err <= 1'b0;
          default: ;
        endcase
      end
      if (w_drop) r_err <= 1'b1;
      // Sequencer cursor updates override a same-cycle CURX/CURY write.
      if (w_cur_set) begin
        r_cx <= w_cx_nxt;
        r_cy <= w_cy_nxt;
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_CTRL: begin
        reg_rdata[CTRL_MODE_BIT]   = r_mode;
        reg_rdata[CTRL_BLINK_BIT]  = r_blink;
        reg_rdata[CTRL_CURSOR_BIT] = r_cur_on;
      end
      REG_CURX:   reg_rdata = {1'b0, r_cx};
      REG_CURY:   reg_rdata = {3'b0, r_cy};
      REG_CURCH:  reg_rdata = r_cch;
      REG_HSHIFT: reg_rdata = {4'b0, r_hshift};
      REG_ATTR:   reg_rdata = r_attr;
      REG_PTRLO:  reg_rdata = r_ptr[7:0];
      REG_PTRHI:  reg_rdata = {3'b0, r_ptr[12:8]};
      REG_STATUS: begin
        reg_rdata[STATUS_BUSY_BIT] = w_busy;
        reg_rdata[STATUS_ERR_BIT]  = r_err;
      end
      default: reg_rdata = '0;
    endcase
  end

  // Direct SDATA/CDATA writes are only accepted in IDLE and the sequencer
  // cannot start a write in the cycle after, so the sources never overlap.
  assign s_we    = w_fsm_we | r_sd_pend;
  assign s_waddr = r_sd_pend ? r_sd_addr : w_fsm_waddr;
  assign s_wdata = r_sd_pend ? r_sd_data : w_fsm_sdata;
  assign c_we    = w_fsm_we | r_cd_pend;
  assign c_waddr = r_cd_pend ? r_cd_addr : w_fsm_waddr[10:0];
  assign c_wdata = r_cd_pend ? r_cd_data : w_fsm_cdata;
  assign s_raddr = w_raddr;
  assign c_raddr = w_raddr[10:0];

  assign busy      = w_busy;
  assign mode      = r_mode;
  assign blink_on  = r_blink;
  assign cursor_on = r_cur_on;
  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign cursor_ch = r_cch;
  assign hshift    = r_hshift;

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 25, text rows per screen.
REQ-003 SHALL have port clk, input, 1, single design clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports reg_addr input 4 (register select), reg_wdata input 8, reg_we input 1, reg_rdata output 8 (combinational read of the selected register).
REQ-006 SHALL have port busy, output, 1, high while a PUTC, FILL or SCROLL sequence is running.
REQ-007 SHALL have ports s_waddr output 13, s_wdata output 8, s_we output 1, s_raddr output 13, s_rdata input 8 (screen RAM, 1-cycle read latency).
REQ-008 SHALL have ports c_waddr output 11, c_wdata output 8, c_we output 1, c_raddr output 11, c_rdata input 8 (color RAM, 1-cycle read latency).
REQ-009 SHALL have outputs mode 1, blink_on 1, cursor_on 1, cursor_x 7, cursor_y 5, cursor_ch 8, hshift 4, driving the display engine.

Function
REQ-010 Register map SHALL be: 0 CTRL{bit0 mode, bit1 blink_on, bit2 cursor_on}; 1 CURX; 2 CURY; 3 CURCH; 4 HSHIFT; 5 ATTR; 6 PUTC; 7 PTRLO; 8 PTRHI (bits 4:0); 9 SDATA; A CDATA; B FILL; C STATUS{bit0 busy, bit1 err}; writes to D-F ignored, reads return 0.
REQ-011 A reg_we is accepted on the clk edge it is sampled; while busy, writes to 6, 9, A, B SHALL be dropped and set STATUS.err; writing STATUS with bit1=1 clears err.
REQ-012 CURX/CURY writes SHALL clamp to COLS-1 / ROWS-1.
REQ-013 SDATA write SHALL assert s_we for exactly one cycle on the following cycle at s_waddr=PTR, then PTR increments modulo 8192; CDATA likewise on the color port at PTR[10:0].
REQ-014 PUTC with char 0x0A SHALL write nothing, set x=0, advance row; 0x0D SHALL set x=0 only; any other char SHALL assert s_we and c_we one cycle later at cursor_y*COLS+cursor_x with data char and ATTR, then advance.
REQ-015 Advance: x<COLS-1 -> x+1; else x=0 and row advance; row advance: y<ROWS-1 -> y+1; else SCROLL (or wrap, REQ-024).
REQ-016 States SHALL be IDLE, PUTC, FILL, SCROLL_COPY, SCROLL_CLEAR; busy is high in every state except IDLE.
REQ-017 FILL SHALL write cell i=0..COLS*ROWS-1, one per cycle, s_wdata=reg_wdata captured at the write, c_wdata=ATTR, then set cursor to (0,0) and return to IDLE; busy high exactly COLS*ROWS cycles.
REQ-018 SCROLL_COPY SHALL issue reads at i+COLS and write i one cycle later, for i=0..COLS*(ROWS-2)+COLS-1, both RAMs, one cell per cycle; SCROLL_CLEAR then writes 0x20/ATTR to the last row; cursor ends at (0,ROWS-1); total busy COLS*ROWS+1 cycles.
REQ-019 Address arithmetic SHALL be width-extended to 13 bits before multiply; no write SHALL occur outside 0..COLS*ROWS-1 in PUTC/FILL/SCROLL.
REQ-020 s_we and c_we SHALL never be asserted in the same cycle as a different-address write from another source; SDATA/CDATA direct writes are only legal in IDLE.

Reset
REQ-021 On reset all outputs SHALL be 0 except cursor_ch=0x5F and ATTR=0x07; state IDLE, PTR=0, err=0, busy=0, all write enables 0.
REQ-022 Reset asserted mid-FILL or mid-SCROLL SHALL abort immediately with no further RAM writes.

Configuration
REQ-023 Macro VRAM_WRITER_SCROLL_EN defined: row advance past ROWS-1 SHALL run SCROLL per REQ-018.
REQ-024 Macro undefined: row advance past ROWS-1 SHALL set y=0 with no RAM access; SCROLL states and read ports are absent (s_raddr, c_raddr tied 0).

Structure
REQ-025 Shared package vram_pkg SHALL hold register-address constants, CTRL/STATUS bit positions, state enum type and reset constants (cursor char, attribute).
REQ-026 One sub-module vram_cell_addr SHALL compute y*COLS+x as a 13-bit result; everything else stays in vram_writer.

Verification
REQ-027 Reset, write CURX=79 CURY=0 ATTR=0x1E, PUTC 'A' -> one-cycle s_we at addr 79 data 0x41, c_we data 0x1E, cursor (0,1).
REQ-028 FILL 0x20 -> busy 2000 cycles, 2000 writes addr 0..1999, cursor (0,0), busy drops.
REQ-029 PUTC during FILL -> no extra write, STATUS=0x03; write STATUS 0x02 -> err clears.
REQ-030 With SCROLL_EN, preload row1 cell0=0x42, cursor (0,24), PUTC 0x0A -> addr 0 receives 0x42, addr 1920..1999 receive 0x20, busy 2001 cycles; without macro cursor (0,0), no writes.
REQ-031 PTR=0x1FFF, SDATA 0x55 twice -> writes at 0x1FFF then 0x0000.
REQ-032 Reset asserted at cycle 500 of FILL -> s_we low immediately, busy 0, all outputs at reset values.
